// File: rtl/adder_arbiter_pkg.sv
// Shared constants for the adder arbiter: FSM state encoding and default sizing.
package adder_arbiter_pkg;

  localparam int DEFAULT_SIZE    = 4;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/Adder.sv
// Shared unsigned adder; sum carries the carry-out in its top bit.
module Adder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  localparam int            PW        = ID_W + 1;
  localparam logic [PW-1:0] NUM_REQ_W = PW'(NUM_REQ);

  logic [2*NUM_REQ-1:0] rotated;
  logic [PW-1:0]        offset;
  logic [PW-1:0]        pos;

  always_comb begin
    // Doubling req lets a plain right shift perform the rotation.
    rotated = {req, req} >> ptr;
    offset  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) offset = PW'(k);
    end
    pos = {1'b0, ptr} + offset;
    if (pos >= NUM_REQ_W) pos = pos - NUM_REQ_W;
    winner  = pos[ID_W-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one Adder among NUM_REQ requesters; one transaction
// runs IDLE -> EXEC -> RESP and returns the sum with the owner's id.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int SIZE    = DEFAULT_SIZE,
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*SIZE-1:0] op_a,
  input  logic [NUM_REQ*SIZE-1:0] op_b,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [ID_W-1:0]         result_id,
  output logic [SIZE:0]           result_sum
);

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     w_reg, w_next;
  logic [SIZE-1:0]     a_lat_reg, a_lat_next;
  logic [SIZE-1:0]     b_lat_reg, b_lat_next;
  logic [NUM_REQ-1:0]  grant_reg, grant_next;
  logic                busy_reg, busy_next;
  logic                valid_reg, valid_next;
  logic [ID_W-1:0]     id_reg, id_next;
  logic [SIZE:0]       sum_reg, sum_next;

  logic [SIZE-1:0]     op_a_arr [NUM_REQ];
  logic [SIZE-1:0]     op_b_arr [NUM_REQ];
  logic [ID_W-1:0]     pick_w;
  logic                any_req;
  logic [SIZE:0]       adder_sum;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a_arr[gi] = op_a[gi*SIZE +: SIZE];
    assign op_b_arr[gi] = op_b[gi*SIZE +: SIZE];
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req     (req),
    .ptr     (ptr_reg),
    .winner  (pick_w),
    .any_req (any_req)
  );

  Adder #(.SIZE(SIZE)) u_adder (
    .a   (a_lat_reg),
    .b   (b_lat_reg),
    .sum (adder_sum)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    w_next     = w_reg;
    a_lat_next = a_lat_reg;
    b_lat_next = b_lat_reg;
    grant_next = '0;
    valid_next = valid_reg;
    id_next    = id_reg;
    sum_next   = sum_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = NUM_REQ'(1) << pick_w;
          a_lat_next = op_a_arr[pick_w];
          b_lat_next = op_b_arr[pick_w];
          w_next     = pick_w;
          ptr_next   = (pick_w == ID_W'(NUM_REQ - 1)) ? '0 : pick_w + 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        sum_next   = adder_sum;
        id_next    = w_reg;
        valid_next = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (result_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      w_reg     <= '0;
      a_lat_reg <= '0;
      b_lat_reg <= '0;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      id_reg    <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      w_reg     <= w_next;
      a_lat_reg <= a_lat_next;
      b_lat_reg <= b_lat_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      id_reg    <= id_next;
      sum_reg   <= sum_next;
    end
  end

  assign grant        = grant_reg;
  assign busy         = busy_reg;
  assign result_valid = valid_reg;
  assign result_id    = id_reg;
  assign result_sum   = sum_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: table of transactions with a result scoreboard, then
// hand-written fairness and mid-transaction reset sequences.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  grant;
  logic        busy;
  logic        result_valid;
  logic        result_ready;
  logic [1:0]  result_id;
  logic [4:0]  result_sum;

  adder_arbiter #(.SIZE(4), .NUM_REQ(4), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .op_a         (op_a),
    .op_b         (op_b),
    .grant        (grant),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .result_sum   (result_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    int          delay;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_id;
    logic [4:0]  exp_sum;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [4:0] sum;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_id"},    32'(result_id), 32'd0);
    check({tag, "_sum"},   32'(result_sum), 32'd0);
  endtask

  task automatic run_vec(input int n, input vec_t v);
    exp_t e;
    req          = v.req;
    op_a         = v.a;
    op_b         = v.b;
    result_ready = (v.delay == 0);
    e.id  = v.exp_id;
    e.sum = v.exp_sum;
    sb.push_back(e);
    @(negedge clk);
    check("grant", 32'(grant), 32'(v.exp_grant));
    check("busy_exec", 32'(busy), 32'd1);
    req  = 4'b0000;
    op_a = ~op_a;
    op_b = ~op_b;
    @(negedge clk);
    check("grant_clear", 32'(grant), 32'd0);
    check("valid_rise", 32'(result_valid), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("result_id", 32'(result_id), 32'(e.id));
      check("result_sum", 32'(result_sum), 32'(e.sum));
    end
    for (int d = 0; d < v.delay; d++) begin
      req = 4'b1111;
      @(negedge clk);
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_id", 32'(result_id), 32'(e.id));
      check("hold_sum", 32'(result_sum), 32'(e.sum));
      check("hold_no_grant", 32'(grant), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    req          = 4'b0000;
    result_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", 32'(result_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    $display("txn %0d: req=%b grant_exp=%b id=%0d sum=%0d", n, v.req, v.exp_grant, e.id, e.sum);
  endtask

  initial begin
    logic [3:0] fair_seq [6];
    int         last_cyc;
    int         gcount;

    rst_n        = 1'b0;
    req          = 4'b0000;
    op_a         = 16'h0000;
    op_b         = 16'h0000;
    result_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{4'b0001, 16'h9ab3, 16'h1235, 0, 4'b0001, 2'd0, 5'd8};
    vecs[1] = '{4'b0100, 16'h3F21, 16'h4127, 1, 4'b0100, 2'd2, 5'd16};
    vecs[2] = '{4'b0010, 16'hFF6F, 16'hEE9E, 5, 4'b0010, 2'd1, 5'd15};
    vecs[3] = '{4'b1111, 16'h1A23, 16'h4A56, 0, 4'b0100, 2'd2, 5'd20};
    vecs[4] = '{4'b1001, 16'hC777, 16'h3888, 0, 4'b1000, 2'd3, 5'd15};
    vecs[5] = '{4'b1001, 16'h000F, 16'h111F, 2, 4'b0001, 2'd0, 5'd30};
    vecs[6] = '{4'b1001, 16'h0FFF, 16'h0EEE, 0, 4'b1000, 2'd3, 5'd0};
    vecs[7] = '{4'b0001, 16'hAAA1, 16'hBBB2, 0, 4'b0001, 2'd0, 5'd3};
    vecs[8] = '{4'b0001, 16'h0008, 16'h0008, 1, 4'b0001, 2'd0, 5'd16};
    vecs[9] = '{4'b1001, 16'h5003, 16'h4002, 0, 4'b1000, 2'd3, 5'd9};

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
    end

    // Fairness: all requesters held from reset, consumer always ready.
    fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rst_n = 1'b0;
    @(negedge clk);
    op_a         = 16'h1111;
    op_b         = 16'h2222;
    req          = 4'b1111;
    result_ready = 1'b1;
    rst_n        = 1'b1;
    last_cyc     = -1;
    gcount       = 0;
    for (int cyc = 0; cyc < 40 && gcount < 6; cyc++) begin
      @(negedge clk);
      if (grant != 4'b0000) begin
        check("fair_grant", 32'(grant), 32'(fair_seq[gcount]));
        if (last_cyc >= 0) check("fair_spacing", 32'(cyc - last_cyc), 32'd3);
        $display("txn fair %0d: grant=%b cycle=%0d", gcount, grant, cyc);
        last_cyc = cyc;
        gcount++;
      end
    end
    check("fair_count", 32'(gcount), 32'd6);

    // Now in EXEC of the 0010 grant (ptr=2): abort with an asynchronous reset.
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_reset_valid", 32'(result_valid), 32'd0);
      check("post_reset_grant", 32'(grant), 32'd0);
    end
    req = 4'b1111;
    @(negedge clk);
    check("post_reset_ptr0", 32'(grant), 32'(4'b0001));
    $display("txn reset: grant=%b after abort", grant);
    req = 4'b0000;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
